// File: rtl/game_tick_generator.sv
// Turns a free-running asynchronous slow oscillator into single-cycle game-tick enables on the fast clock,
// with a watchdog stall detector and an SYNC/RUN/STALL resync FSM. Optional input freeze via GAME_TICK_FREEZE_EN.
module game_tick_generator #(
    parameter int TICK_DIV        = 167,
    parameter int WATCHDOG_CYCLES = 8192
) (
    input  logic        fast_clock_in,
    input  logic        reset,
    input  logic        slow_clock_in,
`ifdef GAME_TICK_FREEZE_EN
    input  logic        freeze,
`endif
    output logic        slow_edge,
    output logic        tick_enable,
    output logic [15:0] tick_count,
    output logic        stalled
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WW = $clog2(WATCHDOG_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(WATCHDOG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_s1, r_s2, r_s3;
    logic          r_slow_edge;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [WW-1:0] r_wd, w_wd_nxt;
    logic          r_sync_cnt, w_sync_nxt;
    logic [15:0]   r_tick_count, w_tick_count_nxt;
    logic          w_tick;
    logic          w_wd_expire;
    logic          w_raw_edge;
    logic          w_freeze;

`ifdef GAME_TICK_FREEZE_EN
    assign w_freeze = freeze;
`else
    assign w_freeze = 1'b0;
`endif

    assign w_raw_edge = r_s2 & ~r_s3;

    always_ff @(posedge fast_clock_in or posedge reset) begin
        if (reset) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_slow_edge <= 1'b0;
        end else begin
            r_s1        <= slow_clock_in;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_slow_edge <= w_raw_edge;
        end
    end

    always_ff @(posedge fast_clock_in or posedge reset) begin
        if (reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A slow edge in the expiry cycle always wins over the watchdog.
    assign w_wd_expire = (r_wd == WD_LAST) && !r_slow_edge;

    always_comb begin
        w_state_nxt      = r_state;
        w_presc_nxt      = r_presc;
        w_sync_nxt       = r_sync_cnt;
        w_tick_count_nxt = r_tick_count;
        w_wd_nxt         = r_wd;
        w_tick           = 1'b0;

        if (r_slow_edge) begin
            w_wd_nxt = '0;
        end else if (r_state != ST_STALL) begin
            w_wd_nxt = w_wd_expire ? '0 : r_wd + 1'b1;
        end

        case (r_state)
            ST_SYNC: begin
                if (r_slow_edge) begin
                    if (r_sync_cnt) begin
                        w_state_nxt = ST_RUN;
                        w_presc_nxt = '0;
                        w_sync_nxt  = 1'b0;
                    end else begin
                        w_sync_nxt  = 1'b1;
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_STALL;
                    w_presc_nxt = '0;
                    w_sync_nxt  = 1'b0;
                end
            end
            ST_RUN: begin
                if (r_slow_edge) begin
                    if (!w_freeze) begin
                        if (r_presc == PRESC_LAST) begin
                            w_presc_nxt      = '0;
                            w_tick           = 1'b1;
                            w_tick_count_nxt = r_tick_count + 16'd1;
                        end else begin
                            w_presc_nxt = r_presc + 1'b1;
                        end
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt = ST_STALL;
                    w_presc_nxt = '0;
                    w_sync_nxt  = 1'b0;
                end
            end
            ST_STALL: begin
                // The restarting edge is already the first SYNC edge.
                if (r_slow_edge) begin
                    w_state_nxt = ST_SYNC;
                    w_sync_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
                w_presc_nxt = '0;
                w_sync_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge fast_clock_in or posedge reset) begin
        if (reset) begin
            r_presc      <= '0;
            r_wd         <= '0;
            r_sync_cnt   <= 1'b0;
            r_tick_count <= 16'h0000;
        end else begin
            r_presc      <= w_presc_nxt;
            r_wd         <= w_wd_nxt;
            r_sync_cnt   <= w_sync_nxt;
            r_tick_count <= w_tick_count_nxt;
        end
    end

    assign slow_edge   = r_slow_edge;
    assign tick_enable = w_tick;
    assign tick_count  = r_tick_count;
    assign stalled     = (r_state == ST_STALL);

endmodule

// File: tb/tb_game_tick_generator.sv
// Randomized bench for game_tick_generator against an edge-counting reference model.
module tb_game_tick_generator;

    localparam int TD = 4;
    localparam int WD = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        slow;
    logic        se, te, st;
    logic [15:0] tc;
`ifdef GAME_TICK_FREEZE_EN
    logic        frz;
`endif

    always #5 clk = ~clk;

    game_tick_generator #(.TICK_DIV(TD), .WATCHDOG_CYCLES(WD)) dut (
        .fast_clock_in (clk),
        .reset         (rst),
        .slow_clock_in (slow),
`ifdef GAME_TICK_FREEZE_EN
        .freeze        (frz),
`endif
        .slow_edge     (se),
        .tick_enable   (te),
        .tick_count    (tc),
        .stalled       (st)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: mode 0=SYNC 1=RUN 2=STALL, counted in slow edges and idle cycles.
    int m_mode, m_sync, m_presc, m_wd, m_tc;
    bit m_edge, m_fz;
    bit smp[$];

    int obs_edges, first_tick_edge;
    bit saw_stall;

    task automatic model_reset();
        m_mode = 0; m_sync = 0; m_presc = 0; m_wd = 0; m_tc = 0;
        m_edge = 0; m_fz = 0;
        smp.delete();
        repeat (4) smp.push_back(1'b0);
    endtask

    task automatic model_step(input bit x, input bit fz);
        bit pe, pf;
        pe = m_edge;
        pf = m_fz;
        if (m_mode == 2) begin
            if (pe) begin m_mode = 0; m_sync = 1; m_wd = 0; end
        end else if (pe) begin
            m_wd = 0;
            if (m_mode == 0) begin
                m_sync++;
                if (m_sync == 2) begin m_mode = 1; m_presc = 0; m_sync = 0; end
            end else if (!pf) begin
                m_presc++;
                if (m_presc == TD) begin m_presc = 0; m_tc = (m_tc + 1) % 65536; end
            end
        end else if (m_wd == WD - 1) begin
            m_mode = 2; m_presc = 0; m_sync = 0;
        end else begin
            m_wd++;
        end
        // The edge appears two samples after the slow clock is first seen high.
        smp.push_front(x);
        void'(smp.pop_back());
        m_edge = smp[2] && !smp[3];
        m_fz   = fz;
    endtask

    task automatic cycle(input bit sv, input bit fz);
        bit efz;
        @(negedge clk);
        slow = sv;
        @(posedge clk);
        #1;
`ifdef GAME_TICK_FREEZE_EN
        frz = fz;
        efz = fz;
`else
        efz = 1'b0;
`endif
        model_step(sv, efz);
        #1;
        chk("slow_edge",   int'(se), int'(m_edge));
        chk("tick_enable", int'(te), int'(m_edge && m_mode == 1 && m_presc == TD - 1 && !m_fz));
        chk("tick_count",  int'(tc), m_tc);
        chk("stalled",     int'(st), int'(m_mode == 2));
        if (se) obs_edges++;
        if (te && first_tick_edge == 0) first_tick_edge = obs_edges;
        if (st) saw_stall = 1'b1;
    endtask

    task automatic slow_period(input int hi, input int lo, input bit fz);
        repeat (hi) cycle(1'b1, fz);
        repeat (lo) cycle(1'b0, fz);
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_slow_edge", int'(se), 0);
        chk("rst_tick_en",   int'(te), 0);
        chk("rst_tick_cnt",  int'(tc), 0);
        chk("rst_stalled",   int'(st), 0);
        model_reset();
`ifdef GAME_TICK_FREEZE_EN
        frz = 1'b0;
`endif
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        int hi, lo;
        bit fz;
        rst  = 1'b1;
        slow = 1'b0;
`ifdef GAME_TICK_FREEZE_EN
        frz  = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_slow_edge", int'(se), 0);
        chk("init_tick_en",   int'(te), 0);
        chk("init_tick_cnt",  int'(tc), 0);
        chk("init_stalled",   int'(st), 0);
        #2 rst = 1'b0;

        // Regular slow clock: 30 edges -> 2 SYNC edges, then ticks on edges 6,10,...,30.
        obs_edges = 0; first_tick_edge = 0;
        repeat (30) slow_period(10, 10, 1'b0);
        chk("first_tick_edge", first_tick_edge, 6);
        chk("ticks_after_30",  int'(tc), 7);

        // Stop the slow clock long enough to trip the watchdog.
        saw_stall = 1'b0;
        repeat (100) cycle(1'b0, 1'b0);
        chk("stall_seen",       int'(saw_stall), 1);
        chk("ticks_held_stall", int'(tc), 7);

        // Restart: ticks on the 6th and 10th edge after restart.
        obs_edges = 0; first_tick_edge = 0;
        repeat (10) slow_period(10, 10, 1'b0);
        chk("restart_first_tick", first_tick_edge, 6);
        chk("ticks_after_restart", int'(tc), 9);

        // Edges exactly WD cycles apart land on the expiry cycle and must not stall.
        saw_stall = 1'b0;
        repeat (6) slow_period(4, 60, 1'b0);
        chk("wd_boundary_no_stall", int'(saw_stall), 0);
        slow_period(4, 61, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);
        chk("wd_one_late_stall", int'(saw_stall), 1);

        // Random periods, including gaps straddling the watchdog limit.
        repeat (150) begin
            hi = $urandom_range(2, 12);
            if ($urandom_range(0, 4) == 0) lo = 63 - hi + $urandom_range(0, 2);
            else                           lo = $urandom_range(2, 12);
`ifdef GAME_TICK_FREEZE_EN
            fz = ($urandom_range(0, 3) == 0);
`else
            fz = 1'b0;
`endif
            slow_period(hi, lo, fz);
        end

        // Mid-period reset; the full SYNC sequence must repeat.
        slow_period(10, 4, 1'b0);
        pulse_reset();
        obs_edges = 0; first_tick_edge = 0;
        repeat (10) slow_period(10, 10, 1'b0);
        chk("post_reset_first_tick", first_tick_edge, 6);
        chk("post_reset_ticks",      int'(tc), 2);

`ifdef GAME_TICK_FREEZE_EN
        // Prescaler is 0 here; 10 frozen edges hold everything, then 4 edges give one tick.
        saw_stall = 1'b0;
        repeat (10) slow_period(10, 10, 1'b1);
        chk("freeze_tick_held", int'(tc), 2);
        chk("freeze_no_stall",  int'(saw_stall), 0);
        repeat (4) slow_period(10, 10, 1'b0);
        chk("freeze_release_tick", int'(tc), 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
